// File: rtl/pwm_duty_sequencer.sv
// Push-button duty-level sequencer: debounces a key, cycles through a 4-entry duty table and
// ramps the PWM duty toward the selected level by at most STEP per PWM period.
module pwm_duty_sequencer #(
    parameter logic [19:0] CNT_MAX = 20'd999_999,
    parameter logic [19:0] PERIOD  = 20'd50_000,
    parameter logic [19:0] DUTY_0  = 20'd0,
    parameter logic [19:0] DUTY_1  = 20'd12_500,
    parameter logic [19:0] DUTY_2  = 20'd25_000,
    parameter logic [19:0] DUTY_3  = 20'd50_000,
    parameter logic [19:0] STEP    = 20'd500
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        key_n,
    input  logic        period_end,
    output logic [19:0] duty,
    output logic        duty_load,
    output logic [1:0]  level_idx,
    output logic        busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RAMP = 1'b1;

    logic        r_key_meta;
    logic        r_key_sync;
    logic [19:0] r_db_cnt;
    logic [1:0]  r_level;
    logic [19:0] r_target;
    logic [19:0] r_duty;
    logic        r_duty_load;
    logic [0:0]  r_state;

    logic        w_press;
    logic [1:0]  w_level_next;
    logic [19:0] w_target_sel;
    logic [19:0] w_target_next;
    logic [20:0] w_up_sum;
    logic [20:0] w_dn_diff;
    logic [19:0] w_stepped;
    logic        w_step_en;
    logic [19:0] w_duty_next;
    logic [0:0]  w_state_next;

    // Synchronizer idles high so a released key never looks like a press out of reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_key_meta <= 1'b1;
            r_key_sync <= 1'b1;
        end else begin
            r_key_meta <= key_n;
            r_key_sync <= r_key_meta;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_db_cnt <= 20'd0;
        end else if (r_key_sync) begin
            r_db_cnt <= 20'd0;
        end else if (r_db_cnt != CNT_MAX) begin
            r_db_cnt <= r_db_cnt + 20'd1;
        end
    end

    // Fires only on the saturating increment, so a held key gives one press.
    assign w_press      = ~r_key_sync & (r_db_cnt == CNT_MAX - 20'd1);
    assign w_level_next = r_level + 2'd1;

    always_comb begin
        w_target_sel = DUTY_0;
        case (w_level_next)
            2'd0:    w_target_sel = DUTY_0;
            2'd1:    w_target_sel = DUTY_1;
            2'd2:    w_target_sel = DUTY_2;
            default: w_target_sel = DUTY_3;
        endcase
        if (w_target_sel > PERIOD) begin
            w_target_sel = PERIOD;
        end
    end

    assign w_target_next = w_press ? w_target_sel : r_target;

    // Step toward the current (pre-press) target; 21-bit math keeps borrow/carry visible.
    assign w_up_sum  = {1'b0, r_duty} + {1'b0, STEP};
    assign w_dn_diff = {1'b0, r_duty} - {1'b0, STEP};

    always_comb begin
        w_stepped = r_target;
        if (r_duty < r_target) begin
            if (w_up_sum < {1'b0, r_target}) begin
                w_stepped = w_up_sum[19:0];
            end
        end else begin
            if (!w_dn_diff[20] && (w_dn_diff[19:0] > r_target)) begin
                w_stepped = w_dn_diff[19:0];
            end
        end
    end

    assign w_step_en    = period_end & (r_state == ST_RAMP);
    assign w_duty_next  = w_step_en ? w_stepped : r_duty;
    assign w_state_next = (w_duty_next != w_target_next) ? ST_RAMP : ST_IDLE;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_level     <= 2'd0;
            r_target    <= DUTY_0;
            r_duty      <= DUTY_0;
            r_duty_load <= 1'b0;
            r_state     <= ST_IDLE;
        end else begin
            if (w_press) begin
                r_level <= w_level_next;
            end
            r_target    <= w_target_next;
            r_duty      <= w_duty_next;
            r_duty_load <= w_step_en & (w_stepped != r_duty);
            r_state     <= w_state_next;
        end
    end

    assign duty      = r_duty;
    assign duty_load = r_duty_load;
    assign level_idx = r_level;
    assign busy      = (r_state == ST_RAMP);

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: debounce, level cycling, ramping, retargeting, reset.
// A second instance with STEP=7 shares the stimulus to check clamping on a non-divisible step.
module tb_pwm_duty_sequencer;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        key_n;
    logic        period_end;
    logic        pe_en;
    int          pe_cnt = 0;
    logic [19:0] duty;
    logic        duty_load;
    logic [1:0]  level_idx;
    logic        busy;
    logic [19:0] duty2;
    logic        duty_load2;
    logic [1:0]  level_idx2;
    logic        busy2;

    int n_tests = 0;
    int n_fail  = 0;
    int n_load  = 0;

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) pe_cnt <= (pe_cnt == 49) ? 0 : pe_cnt + 1;
    assign period_end = pe_en && (pe_cnt == 49);

    always @(negedge sys_clk) if (duty_load) n_load++;

    pwm_duty_sequencer #(
        .CNT_MAX(20'd5), .PERIOD(20'd50), .DUTY_0(20'd10), .DUTY_1(20'd25),
        .DUTY_2(20'd40), .DUTY_3(20'd0), .STEP(20'd5)
    ) u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_n(key_n), .period_end(period_end),
        .duty(duty), .duty_load(duty_load), .level_idx(level_idx), .busy(busy)
    );

    pwm_duty_sequencer #(
        .CNT_MAX(20'd5), .PERIOD(20'd50), .DUTY_0(20'd10), .DUTY_1(20'd25),
        .DUTY_2(20'd40), .DUTY_3(20'd0), .STEP(20'd7)
    ) u_dut7 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_n(key_n), .period_end(period_end),
        .duty(duty2), .duty_load(duty_load2), .level_idx(level_idx2), .busy(busy2)
    );

    // Press lands mid-period, well clear of any period_end.
    task automatic press_key();
        while (pe_cnt != 10) @(negedge sys_clk);
        key_n = 1'b0;
        repeat (12) @(negedge sys_clk);
        key_n = 1'b1;
        repeat (3) @(negedge sys_clk);
    endtask

    // Returns at the negedge just after the period_end edge.
    task automatic wait_period(output bit ok);
        int n;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!period_end && n < 60);
        ok = period_end;
        @(negedge sys_clk);
    endtask

    task automatic settle(output bit ok);
        int n;
        n = 0;
        while (busy && n < 600) begin
            @(negedge sys_clk);
            n++;
        end
        ok = !busy;
    endtask

    task automatic test_reset();
        int snap;
        n_tests++;
        if ({duty, level_idx, busy, duty_load} !== {20'd10, 2'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_hold: duty=%0d lvl=%0d busy=%0b load=%0b want 10/0/0/0",
                     duty, level_idx, busy, duty_load);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        snap = n_load;
        repeat (120) @(negedge sys_clk);
        n_tests++;
        if (n_load !== snap) begin
            n_fail++;
            $display("FAIL reset_idle_load: %0d pulses, want 0", n_load - snap);
        end
        n_tests++;
        if ({duty, level_idx, busy} !== {20'd10, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_idle: duty=%0d lvl=%0d busy=%0b want 10/0/0",
                     duty, level_idx, busy);
        end
    endtask

    task automatic test_bounce();
        key_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        key_n = 1'b1;
        repeat (20) @(negedge sys_clk);
        n_tests++;
        if ({duty, level_idx, busy} !== {20'd10, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL bounce: duty=%0d lvl=%0d busy=%0b want 10/0/0", duty, level_idx, busy);
        end
    endtask

    task automatic test_ramp_up();
        bit ok;
        logic [19:0] exp1 [3];
        logic [19:0] exp7 [3];
        exp1 = '{20'd15, 20'd20, 20'd25};
        exp7 = '{20'd17, 20'd24, 20'd25};
        pe_en = 1'b0;
        key_n = 1'b0;
        repeat (200) @(negedge sys_clk);
        key_n = 1'b1;
        n_tests++;
        if ({level_idx, busy, duty, level_idx2, duty2} !== {2'd1, 1'b1, 20'd10, 2'd1, 20'd10})
        begin
            n_fail++;
            $display("FAIL hold_press: lvl=%0d busy=%0b duty=%0d lvl7=%0d duty7=%0d want 1/1/10/1/10",
                     level_idx, busy, duty, level_idx2, duty2);
        end
        pe_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_period(ok);
            n_tests++;
            if (!ok || duty !== exp1[i] || duty_load !== 1'b1) begin
                n_fail++;
                $display("FAIL ramp_up[%0d]: duty=%0d load=%0b want %0d/1",
                         i, duty, duty_load, exp1[i]);
            end
            n_tests++;
            if (duty2 !== exp7[i] || duty_load2 !== 1'b1) begin
                n_fail++;
                $display("FAIL ramp_up_step7[%0d]: duty=%0d load=%0b want %0d/1",
                         i, duty2, duty_load2, exp7[i]);
            end
        end
        @(negedge sys_clk);
        n_tests++;
        if ({busy, busy2, duty_load} !== 3'b000) begin
            n_fail++;
            $display("FAIL ramp_up_done: busy=%0b busy7=%0b load=%0b want 0/0/0",
                     busy, busy2, duty_load);
        end
    endtask

    task automatic test_interrupt();
        bit ok;
        press_key();
        wait_period(ok);
        n_tests++;
        if (!ok || duty !== 20'd30 || level_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL intr_first: duty=%0d lvl=%0d want 30/2", duty, level_idx);
        end
        press_key();
        n_tests++;
        if (level_idx !== 2'd3 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL intr_press: lvl=%0d busy=%0b want 3/1", level_idx, busy);
        end
        for (int i = 0; i < 6; i++) begin
            wait_period(ok);
            n_tests++;
            if (!ok || duty !== 20'(25 - 5 * i)) begin
                n_fail++;
                $display("FAIL intr_down[%0d]: duty=%0d want %0d", i, duty, 25 - 5 * i);
            end
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL intr_done: busy=%0b want 0", busy);
        end
    endtask

    task automatic test_ramp_down();
        bit ok;
        int snap;
        for (int i = 0; i < 3; i++) begin
            press_key();
            settle(ok);
        end
        n_tests++;
        if (!ok || duty !== 20'd40 || level_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL down_setup: duty=%0d lvl=%0d want 40/2", duty, level_idx);
        end
        press_key();
        n_tests++;
        if (level_idx !== 2'd3 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL down_press: lvl=%0d busy=%0b want 3/1", level_idx, busy);
        end
        for (int i = 0; i < 8; i++) begin
            wait_period(ok);
            n_tests++;
            if (!ok || duty !== 20'(35 - 5 * i) || duty_load !== 1'b1) begin
                n_fail++;
                $display("FAIL down[%0d]: duty=%0d load=%0b want %0d/1",
                         i, duty, duty_load, 35 - 5 * i);
            end
        end
        @(negedge sys_clk);
        n_tests++;
        if (busy !== 1'b0 || duty_load !== 1'b0) begin
            n_fail++;
            $display("FAIL down_done: busy=%0b load=%0b want 0/0", busy, duty_load);
        end
        snap = n_load;
        wait_period(ok);
        n_tests++;
        if (!ok || duty !== 20'd0 || n_load !== snap) begin
            n_fail++;
            $display("FAIL down_floor: duty=%0d loads=%0d want 0/0", duty, n_load - snap);
        end
    endtask

    task automatic test_coincide();
        bit ok;
        press_key();
        settle(ok);
        press_key();
        settle(ok);
        press_key();
        wait_period(ok);
        n_tests++;
        if (!ok || duty !== 20'd30 || level_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL coin_setup: duty=%0d lvl=%0d want 30/2", duty, level_idx);
        end
        // Press fires on the 7th edge after key_n drops: the period_end edge.
        while (pe_cnt != 43) @(negedge sys_clk);
        key_n = 1'b0;
        wait_period(ok);
        key_n = 1'b1;
        n_tests++;
        if (!ok || {duty, level_idx, duty_load, busy} !== {20'd35, 2'd3, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL coin_step: duty=%0d lvl=%0d load=%0b busy=%0b want 35/3/1/1",
                     duty, level_idx, duty_load, busy);
        end
        wait_period(ok);
        n_tests++;
        if (!ok || duty !== 20'd30) begin
            n_fail++;
            $display("FAIL coin_reverse: duty=%0d want 30", duty);
        end
        settle(ok);
        n_tests++;
        if (!ok || duty !== 20'd0) begin
            n_fail++;
            $display("FAIL coin_done: duty=%0d want 0", duty);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int snap;
        press_key();
        wait_period(ok);
        n_tests++;
        if (!ok || duty !== 20'd5 || busy !== 1'b1 || duty_load !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_setup: duty=%0d busy=%0b load=%0b want 5/1/1",
                     duty, busy, duty_load);
        end
        #3 sys_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({duty, level_idx, busy, duty_load} !== {20'd10, 2'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rmid_async: duty=%0d lvl=%0d busy=%0b load=%0b want 10/0/0/0",
                     duty, level_idx, busy, duty_load);
        end
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        snap = n_load;
        repeat (120) @(negedge sys_clk);
        n_tests++;
        if (n_load !== snap || {duty, level_idx, busy} !== {20'd10, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL rmid_after: loads=%0d duty=%0d lvl=%0d busy=%0b want 0/10/0/0",
                     n_load - snap, duty, level_idx, busy);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        key_n     = 1'b1;
        pe_en     = 1'b1;
        repeat (3) @(negedge sys_clk);
        test_reset();
        test_bounce();
        test_ramp_up();
        test_interrupt();
        test_ramp_down();
        test_coincide();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
